// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and flag layout for the sequential ALU.
package alu_pkg;

  // Base group: ctrl[4]=0, operation in ctrl[3:0]
  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_EQ    = 5'b00010;
  localparam logic [4:0] OP_NEQ   = 5'b00011;
  localparam logic [4:0] OP_AND   = 5'b00100;
  localparam logic [4:0] OP_OR    = 5'b00101;
  localparam logic [4:0] OP_ADDA  = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_SLL   = 5'b01000;
  localparam logic [4:0] OP_SRL   = 5'b01001;
  localparam logic [4:0] OP_SRA   = 5'b01010;
  localparam logic [4:0] OP_SLTU  = 5'b01100;
  localparam logic [4:0] OP_SLT   = 5'b01111;

  // Mul/div group: ctrl[4]=1, ctrl[3:2] don't care, operation in ctrl[1:0]
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULHU = 5'b10001;
  localparam logic [4:0] OP_DIVU  = 5'b10010;
  localparam logic [4:0] OP_REMU  = 5'b10011;

  localparam int FLG_Z = 0;
  localparam int FLG_S = 1;
  localparam int FLG_V = 2;
  localparam int FLG_C = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic s, input logic z);
    logic [3:0] f;
    f        = 4'b0000;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_S] = s;
    f[FLG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback handshake bundle between the core and the sequential ALU.
interface alu_seq_if #(
  parameter int N = 32
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [4:0]   ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, A, B, ctrl, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, A, B, ctrl, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// clock. N iterations after start; done_o marks the last one and res_o then
// carries the value that iteration produces, so the caller can register it
// on the same edge.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [4:0]   op_i,
  output logic         done_o,
  output logic [N-1:0] res_o
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    opa_q;
  logic [N-1:0]    opb_q, opb_d;
  logic [4:0]      op_q;
  logic            is_div;
  logic [N:0]      rem_sh, rem_diff;
  logic            quo_bit;

  // acc holds {remainder, quotient} for divide and the growing product for multiply
  assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

  // One iteration of whichever algorithm is loaded
  always_comb begin
    rem_sh   = {acc_q[2*N-1:N], acc_q[N-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    quo_bit  = ~rem_diff[N];
    acc_d    = acc_q;
    opb_d    = opb_q;
    if (is_div) begin
      acc_d = {(quo_bit ? rem_diff[N-1:0] : rem_sh[N-1:0]), acc_q[N-2:0], quo_bit};
    end else begin
      // MSB-first multiplier scan: shift product left, add A when bit set
      acc_d = {acc_q[2*N-2:0], 1'b0} + (opb_q[N-1] ? {{N{1'b0}}, opa_q} : {(2*N){1'b0}});
      opb_d = {opb_q[N-2:0], 1'b0};
    end
  end

  // High half is the product high word or the remainder; low half the rest
  always_comb begin
    case (op_q)
      OP_MULHU, OP_REMU: res_o = acc_d[2*N-1:N];
      default:           res_o = acc_d[N-1:0];
    endcase
  end

  assign done_o = busy_q && (cnt_q == CNT_LAST);

  // Load on start, then iterate until the counter reaches its last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      op_q   <= OP_MUL;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      opa_q  <= a_i;
      opb_q  <= b_i;
      op_q   <= op_i;
      acc_q  <= ((op_i == OP_DIVU) || (op_i == OP_REMU)) ? {{N{1'b0}}, a_i} : '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle base ops plus an iterative mul/div group.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | empty, ready for a new op
//   ST_CALC | mul/div iterating, input side stalled
//   ST_DONE | result/flags presented, held until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  state_t         state_q;
  logic [N-1:0]   result_q;
  logic [3:0]     flags_q;
  logic           out_valid_q;

  logic           in_ready;
  logic           accept;
  logic           md_start;
  logic           md_done;
  logic [N-1:0]   md_res;

  logic [N:0]     add_sum, sub_dif;
  logic           add_v, sub_v;
  logic [SHW-1:0] shamt;
  logic [N-1:0]   base_res_d;
  logic           base_c_d, base_v_d;
  logic [3:0]     base_flg_d;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign md_start = accept && bus.ctrl[4];

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  // Base-op datapath; unlisted codes fall through to ADD
  always_comb begin
    add_sum    = {1'b0, bus.A} + {1'b0, bus.B};
    sub_dif    = {1'b0, bus.A} + {1'b0, ~bus.B} + {{N{1'b0}}, 1'b1};
    add_v      = (bus.A[N-1] == bus.B[N-1]) && (add_sum[N-1] != bus.A[N-1]);
    sub_v      = (bus.A[N-1] != bus.B[N-1]) && (sub_dif[N-1] != bus.A[N-1]);
    shamt      = bus.B[SHW-1:0];
    base_res_d = add_sum[N-1:0];
    base_c_d   = add_sum[N];
    base_v_d   = add_v;
    case ({1'b0, bus.ctrl[3:0]})
      OP_SUB: begin
        base_res_d = sub_dif[N-1:0];
        base_c_d   = sub_dif[N];
        base_v_d   = sub_v;
      end
      OP_ADDA: base_res_d = {add_sum[N-1:1], 1'b0};
      OP_EQ: begin
        base_res_d = {{(N-1){1'b0}}, (bus.A == bus.B)};
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_NEQ: begin
        base_res_d = {{(N-1){1'b0}}, (bus.A != bus.B)};
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_AND: begin
        base_res_d = bus.A & bus.B;
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_OR: begin
        base_res_d = bus.A | bus.B;
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_XOR: begin
        base_res_d = bus.A ^ bus.B;
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_SLL: begin
        base_res_d = bus.A << shamt;
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_SRL: begin
        base_res_d = bus.A >> shamt;
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_SRA: begin
        base_res_d = $signed(bus.A) >>> shamt;
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_SLTU: begin
        base_res_d = {{(N-1){1'b0}}, (bus.A < bus.B)};
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      OP_SLT: begin
        base_res_d = {{(N-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
        base_c_d   = 1'b0;
        base_v_d   = 1'b0;
      end
      default: ;
    endcase
    base_flg_d = pack_flags(base_c_d, base_v_d, base_res_d[N-1], (base_res_d == '0));
  end

  // ctrl[3:2] are normalised away so the iterator only sees the four group codes
  alu_muldiv_iter #(.N(N)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .op_i    ({3'b100, bus.ctrl[1:0]}),
    .done_o  (md_done),
    .res_o   (md_res)
  );

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= pack_flags(1'b0, 1'b0, 1'b0, 1'b1);
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (bus.ctrl[4]) begin
              state_q     <= ST_CALC;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= ST_DONE;
              result_q    <= base_res_d;
              flags_q     <= base_flg_d;
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == ST_DONE) && bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_CALC: begin
          if (md_done) begin
            state_q     <= ST_DONE;
            result_q    <= md_res;
            flags_q     <= pack_flags(1'b0, 1'b0, md_res[N-1], (md_res == '0));
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=32): directed vector table, handshake
// corner sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_seq_if #(.N(32)) bus ();

  alu_seq #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [3:0]  exp_flg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the op definitions
  function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f);
    longint unsigned ua, ub, prod;
    longint          sa, sb, sres, lim_hi, lim_lo;
    logic            cf, vf;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    lim_hi = 2147483647;
    lim_lo = -lim_hi - 1;
    prod = ua * ub;
    cf = 1'b0;
    vf = 1'b0;
    r = '0;
    if (c[4]) begin
      case (c[1:0])
        2'd0: r = prod[31:0];
        2'd1: r = prod[63:32];
        2'd2: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      case (c[3:0])
        4'd1: begin
          r = a - b;
          cf = (a >= b);
          sres = sa - sb;
          vf = (sres > lim_hi) || (sres < lim_lo);
        end
        4'd2:  r = (a == b) ? 1 : 0;
        4'd3:  r = (a != b) ? 1 : 0;
        4'd4:  r = a & b;
        4'd5:  r = a | b;
        4'd7:  r = a ^ b;
        4'd8:  r = a << b[4:0];
        4'd9:  r = a >> b[4:0];
        4'd10: begin
          sres = sa >>> b[4:0];
          r = sres[31:0];
        end
        4'd12: r = (a < b) ? 1 : 0;
        4'd15: r = (sa < sb) ? 1 : 0;
        default: begin
          r = a + b;
          if (c[3:0] == 4'd6) r[0] = 1'b0;
          cf = (ua + ub) > 64'hFFFF_FFFF;
          sres = sa + sb;
          vf = (sres > lim_hi) || (sres < lim_lo);
        end
      endcase
    end
    f = {cf, vf, r[31], (r == 0)};
  endfunction

  // Issue one op (out_ready assumed high) and collect result, latency in
  // edges from the accepting edge, and stalled cycles seen on in_ready.
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f,
                        output int lat, output int busy);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 64'(guard < 100), 64'd1);
    bus.ctrl = c;
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.ctrl = 5'($urandom_range(0, 31));
    lat = 1;
    busy = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      if (!bus.in_ready) busy++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = bus.result;
    f = bus.flags;
  endtask

  logic [31:0] r, er, a, b;
  logic [3:0]  f, ef;
  logic [4:0]  c;
  int          lat, busy;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.ctrl = '0;

    vecs.push_back('{"add_wrap",  OP_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1001});
    vecs.push_back('{"add_ovf",   OP_ADD,   32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0110});
    vecs.push_back('{"sub_borrow",OP_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 4'b0010});
    vecs.push_back('{"sub_nobor", OP_SUB,   32'd7,         32'd5,         32'd2,         4'b1000});
    vecs.push_back('{"sub_zero",  OP_SUB,   32'd5,         32'd5,         32'd0,         4'b1001});
    vecs.push_back('{"sub_ovf",   OP_SUB,   32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b1100});
    vecs.push_back('{"mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0010});
    vecs.push_back('{"mul_max",   OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         4'b0000});
    vecs.push_back('{"divu",      OP_DIVU,  32'd100,       32'd7,         32'd14,        4'b0000});
    vecs.push_back('{"remu",      OP_REMU,  32'd100,       32'd7,         32'd2,         4'b0000});
    vecs.push_back('{"divu_z",    OP_DIVU,  32'd9,         32'd0,         32'hFFFF_FFFF, 4'b0010});
    vecs.push_back('{"remu_z",    OP_REMU,  32'd9,         32'd0,         32'd9,         4'b0000});
    vecs.push_back('{"mul_alias", 5'b11100, 32'd6,         32'd7,         32'd42,        4'b0000});
    vecs.push_back('{"sra",       OP_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, 4'b0010});
    vecs.push_back('{"srl",       OP_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, 4'b0000});
    vecs.push_back('{"sll_mask",  OP_SLL,   32'd1,         32'h21,        32'd2,         4'b0000});
    vecs.push_back('{"slt",       OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0000});
    vecs.push_back('{"sltu",      OP_SLTU,  32'd1,         32'hFFFF_FFFF, 32'd1,         4'b0000});
    vecs.push_back('{"eq",        OP_EQ,    32'd5,         32'd5,         32'd1,         4'b0000});
    vecs.push_back('{"neq",       OP_NEQ,   32'd5,         32'd5,         32'd0,         4'b0001});
    vecs.push_back('{"adda",      OP_ADDA,  32'd3,         32'd4,         32'd6,         4'b0000});
    vecs.push_back('{"add_1011",  5'b01011, 32'd2,         32'd3,         32'd5,         4'b0000});
    vecs.push_back('{"xor",       OP_XOR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 4'b0000});

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result",    64'(bus.result),    64'd0);
    check("rst_flags",     64'(bus.flags),     64'b0001);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready),  64'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, r, f, lat, busy);
      check({vecs[i].name, "_res"},  64'(r),    64'(vecs[i].exp_res));
      check({vecs[i].name, "_flg"},  64'(f),    64'(vecs[i].exp_flg));
      check({vecs[i].name, "_lat"},  64'(lat),  vecs[i].ctrl[4] ? 64'd33 : 64'd1);
      check({vecs[i].name, "_busy"}, 64'(busy), vecs[i].ctrl[4] ? 64'd32 : 64'd0);
    end

    // Back-to-back base ops at full throughput
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.ctrl = OP_SRA; bus.A = 32'h8000_0000; bus.B = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.ctrl = OP_SLT; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1;
    @(negedge clk);
    check("b2b_first_valid", 64'(bus.out_valid), 64'd1);
    check("b2b_first_res",   64'(bus.result),    64'hF800_0000);
    check("b2b_in_ready",    64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", 64'(bus.out_valid), 64'd1);
    check("b2b_second_res",   64'(bus.result),    64'd1);
    check("b2b_second_flg",   64'(bus.flags),     64'b0000);

    // Consumer stall: result holds and the pending op waits
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.ctrl = OP_SRA; bus.A = 32'h8000_0000; bus.B = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.ctrl = OP_SLT; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_res",      64'(bus.result),    64'hF800_0000);
      check("stall_valid",    64'(bus.out_valid), 64'd1);
      check("stall_in_ready", 64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("stall_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stall_second_res", 64'(bus.result), 64'd1);

    // Reset in the middle of a divide
    bus.ctrl = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("calc_in_ready", 64'(bus.in_ready),  64'd0);
    check("calc_valid",    64'(bus.out_valid), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst_valid",    64'(bus.out_valid), 64'd0);
    check("midrst_result",   64'(bus.result),    64'd0);
    check("midrst_flags",    64'(bus.flags),     64'b0001);
    check("midrst_in_ready", 64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst_valid", 64'(bus.out_valid), 64'd0);
    run_op(OP_ADD, 32'd2, 32'd3, r, f, lat, busy);
    check("postrst_add_res", 64'(r),   64'd5);
    check("postrst_add_lat", 64'(lat), 64'd1);
    run_op(OP_DIVU, 32'd100, 32'd7, r, f, lat, busy);
    check("postrst_div_res", 64'(r),   64'd14);
    check("postrst_div_lat", 64'(lat), 64'd33);

    // Randomized ops against the reference model
    for (int i = 0; i < 300; i++) begin
      c = 5'($urandom_range(0, 31));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 40));
        1: a = 32'($urandom_range(0, 300));
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) b = '0;
      model(c, a, b, er, ef);
      run_op(c, a, b, r, f, lat, busy);
      check("rand_res", 64'(r),   64'(er));
      check("rand_flg", 64'(f),   64'(ef));
      check("rand_lat", 64'(lat), c[4] ? 64'd33 : 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
